// File: rtl/tdc_multichannel_stamper.sv
// Multichannel TDC back end: samples thermometer taps, detects hit entry, stamps {coarse, fine}, queues in a FIFO.
// Latency: hit sampled in cycle n is visible at the FIFO head in cycle n+3; writes stall while the FIFO is full.
module tdc_multichannel_stamper #(
  parameter int N_CH       = 4,
  parameter int TAPS       = 32,
  parameter int FINE_W     = $clog2(TAPS + 1),
  parameter int COARSE_W   = 48,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [N_CH*TAPS-1:0]        thermo_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_W-1:0]             out_channel,
  output logic [COARSE_W-1:0]         out_coarse,
  output logic [FINE_W-1:0]           out_fine,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 lost_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } hit_t;

  typedef enum logic [1:0] {ARMED, PENDING, DEAD} ch_state_t;

  function automatic logic [FINE_W-1:0] ones(input logic [TAPS-1:0] v);
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) n = n + FINE_W'(v[i]);
    return n;
  endfunction

  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] smp_coarse;
  logic [TAPS-1:0]     smp [N_CH];
  logic [N_CH-1:0]     smp_lsb_q;
  logic [N_CH-1:0]     hit_edge;
  logic [N_CH-1:0]     smp_zero;

  ch_state_t           state     [N_CH];
  ch_state_t           state_nxt [N_CH];
  logic [N_CH-1:0]     pend;
  logic [N_CH-1:0]     capture;
  logic [N_CH-1:0]     drop;
  logic [FINE_W-1:0]   hit_fine   [N_CH];
  logic [COARSE_W-1:0] hit_coarse [N_CH];

  logic [CH_W-1:0]     rr_ptr;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic [N_CH-1:0]     grant_oh;
  int                  arb_idx;

  logic [7:0]          drop_cnt;
  logic [16:0]         lost_sum;

  hit_t                mem [FIFO_DEPTH];
  hit_t                wr_entry;
  hit_t                head;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                do_rd;

  // S1: sample taps together with the coarse time they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coarse     <= '0;
      smp_coarse <= '0;
      smp_lsb_q  <= '0;
      for (int c = 0; c < N_CH; c++) smp[c] <= '0;
    end else begin
      if (enable) coarse <= coarse + COARSE_W'(1);
      smp_coarse <= coarse;
      for (int c = 0; c < N_CH; c++) begin
        smp[c]       <= thermo_in[c*TAPS +: TAPS];
        smp_lsb_q[c] <= smp[c][0];
      end
    end
  end

  always_comb begin
    hit_edge = '0;
    smp_zero = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit_edge[c] = smp[c][0] & ~smp_lsb_q[c];
      smp_zero[c] = (smp[c] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) state[c] <= ARMED;
    end else begin
      for (int c = 0; c < N_CH; c++) state[c] <= state_nxt[c];
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_nxt[c] = state[c];
      case (state[c])
        ARMED:   if (hit_edge[c] && enable) state_nxt[c] = PENDING;
        PENDING: if (grant_oh[c])           state_nxt[c] = DEAD;
        DEAD:    if (smp_zero[c])           state_nxt[c] = ARMED;
        default:                            state_nxt[c] = ARMED;
      endcase
    end
  end

  always_comb begin
    pend    = '0;
    capture = '0;
    drop    = '0;
    for (int c = 0; c < N_CH; c++) begin
      pend[c]    = (state[c] == PENDING);
      capture[c] = (state[c] == ARMED) && hit_edge[c] && enable;
      drop[c]    = (state[c] == PENDING) && hit_edge[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        hit_fine[c]   <= '0;
        hit_coarse[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (capture[c]) begin
          hit_fine[c]   <= ones(smp[c]);
          hit_coarse[c] <= smp_coarse;
        end
      end
    end
  end

  // S3: round-robin search starting at rr_ptr; nothing is granted into a full FIFO
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
      if (!grant_vld && pend[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(arb_idx);
      end
    end
    if (full) grant_vld = 1'b0;
  end

  always_comb begin
    grant_oh = '0;
    for (int c = 0; c < N_CH; c++) grant_oh[c] = grant_vld && (grant_idx == CH_W'(c));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int c = 0; c < N_CH; c++) drop_cnt = drop_cnt + 8'(drop[c]);
    lost_sum = {1'b0, lost_count} + 17'(drop_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lost_count <= '0;
    end else begin
      lost_count <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end
  end

  always_comb begin
    wr_entry.ch     = grant_idx;
    wr_entry.coarse = hit_coarse[grant_idx];
    wr_entry.fine   = hit_fine[grant_idx];
  end

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign do_rd = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (grant_vld) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (grant_vld) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)     rd_ptr <= rd_ptr + AW'(1);
      case ({grant_vld, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // head fields are forced to zero while empty so reset and idle outputs read 0
  assign head        = mem[rd_ptr];
  assign out_valid   = (level != '0);
  assign out_channel = out_valid ? head.ch     : '0;
  assign out_coarse  = out_valid ? head.coarse : '0;
  assign out_fine    = out_valid ? head.fine   : '0;
  assign fifo_level  = level;

endmodule

// File: tb/tb_tdc_multichannel_stamper.sv
// Directed bench for tdc_multichannel_stamper; a second instance with a 4-bit coarse counter exercises wrap-around.
module tb_tdc_multichannel_stamper;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [127:0] thermo;
  logic         out_ready;
  logic         out_valid;
  logic [1:0]   out_channel;
  logic [47:0]  out_coarse;
  logic [5:0]   out_fine;
  logic [4:0]   fifo_level;
  logic [15:0]  lost_count;

  logic         w_valid;
  logic [1:0]   w_channel;
  logic [3:0]   w_coarse;
  logic [5:0]   w_fine;
  logic [4:0]   w_level;
  logic [15:0]  w_lost;

  int checks;
  int failures;
  int cyc;

  tdc_multichannel_stamper dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .thermo_in(thermo),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_coarse(out_coarse), .out_fine(out_fine), .fifo_level(fifo_level),
    .lost_count(lost_count)
  );

  tdc_multichannel_stamper #(.COARSE_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .thermo_in(thermo),
    .out_valid(w_valid), .out_ready(out_ready), .out_channel(w_channel),
    .out_coarse(w_coarse), .out_fine(w_fine), .fifo_level(w_level),
    .lost_count(w_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // cyc tracks the coarse counter value currently held by the main instance
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n && enable) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    thermo    = '0;
    out_ready = 1'b0;
    step(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    cyc     = 0;
  endtask

  task automatic set_ch(input int c, input logic [31:0] v);
    thermo[c*32 +: 32] = v;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int w;
    w = 0;
    while (!out_valid && w < budget) begin
      step(1);
      w++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; thermo = '1; out_ready = 1'b1;
    step(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (lost_count !== 16'd0) begin failures++; $display("FAIL reset_lost got=%0d exp=0", lost_count); end
    checks++; if ({out_channel, out_coarse, out_fine} !== 56'd0) begin
      failures++; $display("FAIL reset_data got=%0h exp=0", {out_channel, out_coarse, out_fine});
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    step(10);
    set_ch(1, 32'h0000FFFF);
    step(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%0b exp=0", out_valid); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%0b exp=1", out_valid); end
    checks++; if (out_channel !== 2'd1) begin failures++; $display("FAIL t1_channel got=%0d exp=1", out_channel); end
    checks++; if (out_fine !== 6'd16) begin failures++; $display("FAIL t1_fine got=%0d exp=16", out_fine); end
    checks++; if (out_coarse !== 48'd10) begin failures++; $display("FAIL t1_coarse got=%0d exp=10", out_coarse); end
    checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL t1_level got=%0d exp=1", fifo_level); end
    out_ready = 1'b1;
    step(1);
    checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      failures++; $display("FAIL t1_pop got valid=%0b level=%0d exp valid=0 level=0", out_valid, fifo_level);
    end
    checks++; if (lost_count !== 16'd0) begin failures++; $display("FAIL t1_lost got=%0d exp=0", lost_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    out_ready = 1'b1;
    step(3);
    set_ch(0, 32'h00000001);
    set_ch(2, 32'h000000FF);
    set_ch(3, 32'hFFFFFFFF);
    step(3);
    checks++; if ({out_valid, out_channel, out_coarse, out_fine} !== {1'b1, 2'd0, 48'd3, 6'd1}) begin
      failures++; $display("FAIL t2_first got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=0 c=3 f=1", out_valid, out_channel, out_coarse, out_fine);
    end
    step(1);
    checks++; if ({out_valid, out_channel, out_coarse, out_fine} !== {1'b1, 2'd2, 48'd3, 6'd8}) begin
      failures++; $display("FAIL t2_second got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=2 c=3 f=8", out_valid, out_channel, out_coarse, out_fine);
    end
    step(1);
    checks++; if ({out_valid, out_channel, out_coarse, out_fine} !== {1'b1, 2'd3, 48'd3, 6'd32}) begin
      failures++; $display("FAIL t2_third got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=3 c=3 f=32", out_valid, out_channel, out_coarse, out_fine);
    end
    step(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t2_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_fifo_full();
    logic [55:0] exp_q[$];
    logic [31:0] v;
    int          base;
    bit          ok;
    do_reset();
    step(2);
    for (int r = 0; r < 5; r++) begin
      base = cyc;
      v = (32'd1 << (r + 1)) - 32'd1;
      for (int c = 0; c < 4; c++) begin
        set_ch(c, v);
        exp_q.push_back({2'(c), 48'(base), 6'(r + 1)});
      end
      step(1);
      thermo = '0;
      step(7);
    end
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL t3_full_level got=%0d exp=16", fifo_level); end
    checks++; if (lost_count !== 16'd0) begin failures++; $display("FAIL t3_lost_before got=%0d exp=0", lost_count); end
    for (int c = 0; c < 4; c++) set_ch(c, 32'h00000003);
    step(1);
    thermo = '0;
    step(4);
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL t3_level_hold got=%0d exp=16", fifo_level); end
    checks++; if (lost_count !== 16'd4) begin failures++; $display("FAIL t3_lost got=%0d exp=4", lost_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_valid(8, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL t3_drain_timeout entry=%0d got no valid exp valid", k);
      end else if ({out_channel, out_coarse, out_fine} !== exp_q[k]) begin
        failures++; $display("FAIL t3_drain entry=%0d got=%0h exp=%0h", k, {out_channel, out_coarse, out_fine}, exp_q[k]);
      end
      step(1);
    end
    step(3);
    checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      failures++; $display("FAIL t3_empty got valid=%0b level=%0d exp 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_rearm();
    do_reset();
    step(2);
    set_ch(0, 32'h000000FF);
    step(1);
    set_ch(0, 32'h00000000);
    step(4);
    set_ch(0, 32'h00000007);
    step(4);
    checks++; if (fifo_level !== 5'd2) begin failures++; $display("FAIL t4_level got=%0d exp=2", fifo_level); end
    out_ready = 1'b1;
    checks++; if ({out_channel, out_coarse, out_fine} !== {2'd0, 48'd2, 6'd8}) begin
      failures++; $display("FAIL t4_first got ch=%0d c=%0d f=%0d exp ch=0 c=2 f=8", out_channel, out_coarse, out_fine);
    end
    step(1);
    checks++; if ({out_channel, out_coarse, out_fine} !== {2'd0, 48'd7, 6'd3}) begin
      failures++; $display("FAIL t4_second got ch=%0d c=%0d f=%0d exp ch=0 c=7 f=3", out_channel, out_coarse, out_fine);
    end
    step(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t4_drained got=%0b exp=0", out_valid); end

    do_reset();
    step(2);
    set_ch(0, 32'h000000FF);
    step(1);
    set_ch(0, 32'h0000000E);
    step(1);
    set_ch(0, 32'h00000007);
    step(6);
    checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL t4_dead_level got=%0d exp=1", fifo_level); end
    checks++; if (lost_count !== 16'd0) begin failures++; $display("FAIL t4_dead_lost got=%0d exp=0", lost_count); end
    checks++; if (out_fine !== 6'd8) begin failures++; $display("FAIL t4_dead_fine got=%0d exp=8", out_fine); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(17);
    set_ch(2, 32'h00000003);
    step(4);
    checks++; if ({w_valid, w_channel, w_coarse, w_fine} !== {1'b1, 2'd2, 4'd1, 6'd2}) begin
      failures++; $display("FAIL t5_wrap got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=2 c=1 f=2", w_valid, w_channel, w_coarse, w_fine);
    end
    checks++; if (out_coarse !== 48'd17) begin failures++; $display("FAIL t5_wide_coarse got=%0d exp=17", out_coarse); end
    checks++; if (w_level !== 5'd1 || w_lost !== 16'd0) begin
      failures++; $display("FAIL t5_status got level=%0d lost=%0d exp 1/0", w_level, w_lost);
    end
  endtask

  task automatic test_enable();
    do_reset();
    out_ready = 1'b1;
    step(3);
    enable = 1'b0;
    set_ch(0, 32'h00000001);
    step(5);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_blocked got=%0b exp=0", out_valid); end
    thermo = '0;
    step(2);
    enable = 1'b1;
    step(1);
    set_ch(0, 32'h00000001);
    step(3);
    checks++; if ({out_valid, out_channel, out_coarse, out_fine} !== {1'b1, 2'd0, 48'd4, 6'd1}) begin
      failures++; $display("FAIL en_resume got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=0 c=4 f=1", out_valid, out_channel, out_coarse, out_fine);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(2);
    for (int c = 0; c < 4; c++) set_ch(c, 32'h00000001);
    step(1);
    thermo = '0;
    step(7);
    set_ch(0, 32'h00000001);
    step(1);
    thermo = '0;
    step(6);
    checks++; if (fifo_level !== 5'd5) begin failures++; $display("FAIL t6_queued got=%0d exp=5", fifo_level); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0 || lost_count !== 16'd0) begin
      failures++; $display("FAIL t6_async got v=%0b level=%0d lost=%0d exp 0/0/0", out_valid, fifo_level, lost_count);
    end
    step(2);
    reset_n = 1'b1;
    cyc = 0;
    step(4);
    set_ch(1, 32'hFFFFFFFF);
    step(3);
    checks++; if ({out_valid, out_channel, out_coarse, out_fine} !== {1'b1, 2'd1, 48'd4, 6'd32}) begin
      failures++; $display("FAIL t6_after got v=%0b ch=%0d c=%0d f=%0d exp v=1 ch=1 c=4 f=32", out_valid, out_channel, out_coarse, out_fine);
    end
    checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL t6_after_level got=%0d exp=1", fifo_level); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset_n = 1'b0; enable = 1'b0; thermo = '0; out_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_fifo_full();
    test_rearm();
    test_wrap();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
